memory_port_arbiter: RTL

Sequencer and arbiter that shares one external memory port between the fetch stage and the memory-access stage of the pipelined core. It accepts one request per requester and runs at most one bus transaction at a time, with memory-access requests taking priority over fetches. It returns per-requester completion pulses and stall signals for the hazard logic. With the timeout option compiled in, a watchdog aborts hung transactions.

---
 rtl/memory_port_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/memory_port_arbiter.sv
// Shares one external memory port between the fetch and memory-access stages, MEM first.
// Define MEMARB_TIMEOUT_EN to compile in the watchdog that aborts hung transactions.

module memory_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifReq,
  input  logic [31:0] ifAddress,
  output logic [31:0] ifData,
  output logic        ifDone,
  output logic        ifStall,
  input  logic        memReq,
  input  logic        memWrite,
  input  logic [31:0] memAddress,
  input  logic [31:0] memWriteData,
  input  logic [3:0]  memByteEnable,
  output logic [31:0] memReadData,
  output logic        memDone,
  output logic        memStall,
  output logic        busValid,
  output logic        busWrite,
  output logic [31:0] busAddress,
  output logic [31:0] busWriteData,
  output logic [3:0]  busByteEnable,
  input  logic        busReady,
  input  logic        busRespValid,
  input  logic [31:0] busRespData,
  output logic        busError
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e      state_q;
  logic        grant_mem_q;
  logic        if_done_q, mem_done_q;
  logic        bus_valid_q, bus_write_q;
  logic [31:0] bus_addr_q, bus_wdata_q;
  logic [3:0]  bus_be_q;
  logic [31:0] if_data_q, mem_rdata_q;

`ifdef MEMARB_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       bus_error_q;
  logic       timeout;
  logic       abort;

  assign timeout = (cnt_q + 8'd1) == TIMEOUT_CYCLES[7:0];
  // A handshake completing in the limit cycle still wins over the abort.
  assign abort   = timeout & (((state_q == StIssue) & ~busReady) |
                              ((state_q == StWait) & ~busRespValid));
  assign busError = bus_error_q;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign busError = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      grant_mem_q <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      bus_valid_q <= 1'b0;
      bus_write_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
`ifdef MEMARB_TIMEOUT_EN
      cnt_q       <= '0;
      bus_error_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (memReq) begin
            grant_mem_q <= 1'b1;
            bus_write_q <= memWrite;
            bus_addr_q  <= memAddress;
            bus_wdata_q <= memWriteData;
            bus_be_q    <= memByteEnable;
            bus_valid_q <= 1'b1;
            state_q     <= StIssue;
          end else if (ifReq) begin
            grant_mem_q <= 1'b0;
            bus_write_q <= 1'b0;
            bus_addr_q  <= ifAddress;
            bus_wdata_q <= '0;
            bus_be_q    <= 4'hF;
            bus_valid_q <= 1'b1;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          if (busReady) begin
            bus_valid_q <= 1'b0;
            state_q     <= StWait;
          end
        end
        StWait: begin
          if (busRespValid) begin
            if (grant_mem_q) begin
              if (!bus_write_q) mem_rdata_q <= busRespData;
            end else begin
              if_data_q <= busRespData;
            end
            if_done_q  <= ~grant_mem_q;
            mem_done_q <= grant_mem_q;
            state_q    <= StResp;
          end
        end
        StResp: begin
          if_done_q  <= 1'b0;
          mem_done_q <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

`ifdef MEMARB_TIMEOUT_EN
      if (state_q == StIdle) begin
        cnt_q <= '0;
      end else if ((state_q == StIssue) || (state_q == StWait)) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (abort) begin
        bus_valid_q <= 1'b0;
        if_done_q   <= ~grant_mem_q;
        mem_done_q  <= grant_mem_q;
        bus_error_q <= 1'b1;
        state_q     <= StResp;
        if (grant_mem_q) begin
          if (!bus_write_q) mem_rdata_q <= '0;
        end else begin
          if_data_q <= 32'h0000_0013;
        end
      end
`endif
    end
  end

  assign ifData        = if_data_q;
  assign ifDone        = if_done_q;
  assign ifStall       = ifReq & ~if_done_q;
  assign memReadData   = mem_rdata_q;
  assign memDone       = mem_done_q;
  assign memStall      = memReq & ~mem_done_q;
  assign busValid      = bus_valid_q;
  assign busWrite      = bus_write_q;
  assign busAddress    = bus_addr_q;
  assign busWriteData  = bus_wdata_q;
  assign busByteEnable = bus_be_q;

endmodule
